// File: rtl/pipe_defs.sv
`default_nettype none
// ============================================================================
// Module   : pipe_defs (package)
// Brief    : Shared definitions for the inter-stage pipeline registers:
//            stage-buffer state encodings and control-field bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_defs;

  typedef logic [1:0] state_t;

  // Stage-buffer occupancy states
  localparam state_t ST_EMPTY = 2'd0;  // main entry invalid
  localparam state_t ST_ONE   = 2'd1;  // main valid, skid empty
  localparam state_t ST_FULL  = 2'd2;  // main and skid valid

  // Standard CTRL_W = 8 control-field layout shared by all stages
  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUOP_LSB = 4;
  localparam int CTRL_ALUOP_W   = 4;

endpackage : pipe_defs
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_sat_counter
// Brief    : Saturating up-counter with synchronous clear (clear wins over
//            increment). Used for pipeline performance statistics.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  // Count register with asynchronous reset
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Pipeline-stage register with valid/ready handshake, optional
//            2-entry skid buffer, flush-to-bubble and saturating stall count.
//            Payload is never cleared by flush; the control field is zero
//            whenever the stage presents a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf
  import pipe_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Occupancy and main-entry next-state; flush overrides every transfer
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept && (SKID != 0)) begin
            state_d = ST_FULL;
          end else if (drain) begin
            // Going empty: present a bubble, payload left as-is
            state_d     = ST_EMPTY;
            main_ctrl_d = '0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d     = ST_ONE;
            main_data_d = skid_data;
            main_ctrl_d = skid_ctrl;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_ctrl_d = '0;
        end
      endcase
    end
  end

  // Main entry and occupancy registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_q, skid_data_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

      // Skid captures the in-flight entry when the output stalls in ONE
      always_comb begin
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
          skid_ctrl_d = '0;
        end else if ((state_q == ST_ONE) && accept && !drain) begin
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end
      end

      // Skid entry registers
      always_ff @(posedge clk or posedge res) begin
        if (res) begin
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
        end else begin
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
        end
      end

      assign skid_data = skid_data_q;
      assign skid_ctrl = skid_ctrl_q;
      // Ready depends only on registered occupancy (plus reset gating)
      assign in_ready  = !res && (state_q != ST_FULL);
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_ctrl = '0;
      // Single register: accept when empty or when being drained this cycle
      assign in_ready  = !res && (!out_valid || out_ready);
    end
  endgenerate

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .res (res),
    .inc (out_valid & ~out_ready),
    .clr (clr_stats),
    .cnt (stall_cnt)
  );

endmodule : pipe_stage_buf
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Self-checking bench: a SKID=1 (CNT_W=4) and a SKID=0 instance
//            share stimulus and are compared against a FIFO-style model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid, flush, out_ready, clr_stats;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [7:0]  s_out_ctrl;
  logic [3:0]  s_stall;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_data;
  logic [7:0]  n_out_ctrl;
  logic [15:0] n_stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_ctrl(s_out_ctrl), .clr_stats(clr_stats), .stall_cnt(s_stall)
  );

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .out_ctrl(n_out_ctrl), .clr_stats(clr_stats), .stall_cnt(n_stall)
  );

  // Reference model: per instance, a list of held entries {data, ctrl}
  logic [39:0] ent [2][2];
  int          n_ent [2];
  logic [31:0] last_d [2];
  int          stall [2];
  int          stall_max [2];
  int          cap [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n_ent[i]  = 0;
      last_d[i] = '0;
      stall[i]  = 0;
    end
  endtask

  function automatic bit exp_ready(int i);
    if (res) return 1'b0;
    if (cap[i] == 2) return n_ent[i] < 2;
    return (n_ent[i] == 0) || out_ready;
  endfunction

  task automatic model_step(int i);
    bit acc;
    bit drn;
    acc = in_valid && exp_ready(i);
    drn = (n_ent[i] > 0) && out_ready;
    if (clr_stats) stall[i] = 0;
    else if ((n_ent[i] > 0) && !out_ready && (stall[i] < stall_max[i])) stall[i]++;
    if (flush) begin
      n_ent[i] = 0;
    end else begin
      if (drn) begin
        ent[i][0] = ent[i][1];
        n_ent[i]--;
      end
      if (acc) begin
        ent[i][n_ent[i]] = {in_data, in_ctrl};
        n_ent[i]++;
      end
    end
    if (n_ent[i] > 0) last_d[i] = ent[i][0][39:8];
  endtask

  function automatic logic [31:0] exp_data(int i);
    return (n_ent[i] > 0) ? ent[i][0][39:8] : last_d[i];
  endfunction

  function automatic logic [7:0] exp_ctrl(int i);
    return (n_ent[i] > 0) ? ent[i][0][7:0] : 8'h00;
  endfunction

  task automatic check_outs();
    check_eq("s_valid", s_out_valid, n_ent[0] > 0);
    check_eq("s_data",  s_out_data,  exp_data(0));
    check_eq("s_ctrl",  s_out_ctrl,  exp_ctrl(0));
    check_eq("s_stall", s_stall,     stall[0]);
    check_eq("n_valid", n_out_valid, n_ent[1] > 0);
    check_eq("n_data",  n_out_data,  exp_data(1));
    check_eq("n_ctrl",  n_out_ctrl,  exp_ctrl(1));
    check_eq("n_stall", n_stall,     stall[1]);
  endtask

  // One clock cycle with the inputs already applied
  task automatic cycle();
    #1;
    check_eq("s_in_ready", s_in_ready, exp_ready(0));
    check_eq("n_in_ready", n_in_ready, exp_ready(1));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_outs();
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [7:0] c,
                       input bit ordy, input bit fl, input bit clr);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    clr_stats = clr;
  endtask

  initial begin
    cap[0] = 2;  stall_max[0] = 15;
    cap[1] = 1;  stall_max[1] = 65535;
    model_reset();
    res = 1'b1;
    drive(0, '0, '0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_in_ready", s_in_ready, 0);
    check_eq("rst_n_in_ready", n_in_ready, 0);
    check_outs();
    res = 1'b0;
    cycle();

    // Stream 0x100..0x104 with out_ready high
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h100 + k, 8'(k + 1), 1, 0, 0);
      cycle();
      check_eq("stream_s_data", s_out_data, 32'h100 + k);
      check_eq("stream_n_data", n_out_data, 32'h100 + k);
    end
    drive(0, '0, '0, 1, 0, 0);
    cycle();
    check_eq("stream_stall0", s_stall, 0);

    // Backpressure for 3 cycles mid-stream
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h200 + k, 8'(8'h10 + k), !(k >= 2 && k <= 4), 0, 0);
      cycle();
    end
    drive(0, '0, '0, 1, 0, 0);
    repeat (3) cycle();
    check_eq("bp_s_stall3", s_stall, 3);
    check_eq("bp_n_stall3", n_stall, 3);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom_range(0, 255)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 24) == 0);
      cycle();
    end

    // Flush + clear, then saturate the 4-bit counter
    drive(0, '0, '0, 1, 1, 1);
    cycle();
    for (int k = 0; k < 22; k++) begin
      drive(1, 32'h300 + k, 8'hFF, 0, 0, 0);
      cycle();
    end
    check_eq("sat_s_stall", s_stall, 15);
    drive(0, '0, '0, 0, 0, 1);
    cycle();
    check_eq("clr_s_stall", s_stall, 0);
    check_eq("clr_n_stall", n_stall, 0);

    // Flush while FULL with an offered entry
    check_eq("pre_flush_full", s_in_ready, 0);
    drive(1, 32'hDEAD_BEEF, 8'hFF, 0, 1, 0);
    cycle();
    drive(0, '0, '0, 0, 0, 0);
    #1;
    check_eq("flush_s_valid", s_out_valid, 0);
    check_eq("flush_s_ctrl", s_out_ctrl, 8'h00);
    check_eq("flush_s_ready", s_in_ready, 1);
    check_eq("flush_n_valid", n_out_valid, 0);
    cycle();

    // Async reset while FULL
    for (int k = 0; k < 3; k++) begin
      drive(1, $urandom, 8'hFF, 0, 0, 0);
      cycle();
    end
    #2 res = 1'b1;
    #1;
    model_reset();
    check_eq("ares_s_ready", s_in_ready, 0);
    check_eq("ares_n_ready", n_in_ready, 0);
    check_outs();
    @(posedge clk);
    #1;
    check_eq("ares_hold_ready", s_in_ready, 0);
    res = 1'b0;
    drive(0, '0, '0, 1, 0, 0);
    cycle();

    // Trailing random traffic after reset
    for (int k = 0; k < 60; k++) begin
      drive($urandom_range(0, 1) != 0, $urandom, 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) != 0, $urandom_range(0, 29) == 0, 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_buf
`default_nettype wire
